// File: rtl/uart_rx_fifo.sv
// UART RX byte buffer: FWFT FIFO with sticky overflow, level threshold and idle-timeout interrupt sources.
// Data is visible one cycle after the rx_valid write. A write into a full FIFO is dropped unless a read fires in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH         = 16,
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     sample_tick,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    input  logic [$clog2(DEPTH):0]   thresh,
    output logic                     irq_thresh,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic                     rx_timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_TICKS);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] idle_cnt;
    logic          empty;
    logic          rd_fire;
    logic          wr_en;
    logic          drop;

    // The extra pointer bit separates full from empty when the indices match.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign out_valid  = !empty;
    assign out_data   = mem[rd_ptr[AW-1:0]];
    assign level      = wr_ptr - rd_ptr;
    assign irq_thresh = (thresh != '0) && (level >= thresh);
    assign rx_timeout = (idle_cnt == TMAX) && !empty;

    assign rd_fire = out_valid && out_ready;
    assign wr_en   = rx_valid && (!full || rd_fire);
    assign drop    = rx_valid && full && !rd_fire;

    always_ff @(posedge clk) begin
        if (wr_en && rstn) begin
            mem[wr_ptr[AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            idle_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // A fresh drop beats a simultaneous clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (empty || wr_en || rd_fire) begin
                idle_cnt <= '0;
            end else if (sample_tick && (idle_cnt != TMAX)) begin
                idle_cnt <= idle_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: queue-based reference model checked every cycle plus literal spot checks.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int TT    = 640;

    logic       clk = 1'b0;
    logic       rstn;
    logic       sample_tick;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] level;
    logic       full;
    logic [4:0] thresh;
    logic       irq_thresh;
    logic       overflow;
    logic       ovf_clr;
    logic       rx_timeout;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    byte unsigned q[$];
    bit m_ovf;
    int m_idle;
    int sz;

    uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_TICKS(TT)) dut (
        .clk(clk), .rstn(rstn), .sample_tick(sample_tick),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .full(full), .thresh(thresh), .irq_thresh(irq_thresh),
        .overflow(overflow), .ovf_clr(ovf_clr), .rx_timeout(rx_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue, a sticky flag and an idle tick count.
    always @(posedge clk) begin
        bit rd, wr_ok, drop, was_empty;
        if (!rstn) begin
            q.delete();
            m_ovf  = 0;
            m_idle = 0;
        end else begin
            was_empty = (q.size() == 0);
            rd        = !was_empty && out_ready;
            wr_ok     = rx_valid && (q.size() < DEPTH || rd);
            drop      = rx_valid && !wr_ok;
            if (rd) void'(q.pop_front());
            if (wr_ok) q.push_back(rx_data);
            if (drop) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            if (was_empty || wr_ok || rd) m_idle = 0;
            else if (sample_tick && m_idle < TT) m_idle++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            sz = q.size();
            check("m_valid", 32'(out_valid), 32'(sz != 0));
            if (sz != 0) check("m_data", 32'(out_data), 32'(q[0]));
            check("m_level", 32'(level), 32'(sz));
            check("m_full", 32'(full), 32'(sz == DEPTH));
            check("m_irq", 32'(irq_thresh), 32'(thresh != 0 && sz >= int'(thresh)));
            check("m_ovf", 32'(overflow), 32'(m_ovf));
            check("m_tmo", 32'(rx_timeout), 32'(m_idle == TT && sz != 0));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        rx_valid    = 0;
        ovf_clr     = 0;
        sample_tick = 0;
    endtask

    task automatic wr(input byte unsigned b);
        rx_valid = 1;
        rx_data  = b;
        cyc();
    endtask

    task automatic fill(input byte unsigned base, input int n);
        for (int i = 0; i < n; i++) wr(base + 8'(i));
    endtask

    task automatic drain(input int n);
        out_ready = 1;
        for (int i = 0; i < n; i++) cyc();
        out_ready = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            sample_tick = 1;
            cyc();
        end
    endtask

    initial begin
        rstn = 0; sample_tick = 0; rx_data = 0; rx_valid = 0;
        out_ready = 0; thresh = 0; ovf_clr = 0;
        cyc(); cyc();
        rstn = 1;
        chk_en = 1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_full", 32'(full), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_tmo", 32'(rx_timeout), 0);

        // 1) basic FWFT order
        wr(8'h41); wr(8'h42); wr(8'h43);
        check("t1_level3", 32'(level), 3);
        check("t1_head", 32'(out_data), 32'h41);
        out_ready = 1;
        check("t1_r0", 32'(out_data), 32'h41); cyc();
        check("t1_r1", 32'(out_data), 32'h42); cyc();
        check("t1_r2", 32'(out_data), 32'h43); cyc();
        out_ready = 0;
        check("t1_empty", 32'(out_valid), 0);
        check("t1_level0", 32'(level), 0);

        // 2) overflow on the 17th byte
        fill(8'h10, 16);
        check("t2_full", 32'(full), 1);
        check("t2_noovf", 32'(overflow), 0);
        wr(8'hEE);
        check("t2_ovf", 32'(overflow), 1);
        check("t2_level16", 32'(level), 16);
        out_ready = 1;
        for (int i = 0; i < 16; i++) begin
            check("t2_drain", 32'(out_data), 32'(8'h10 + i));
            cyc();
        end
        out_ready = 0;
        check("t2_drained", 32'(out_valid), 0);
        ovf_clr = 1; cyc();
        check("t2_ovf_clr", 32'(overflow), 0);

        // 3) write and read in the same cycle while full
        fill(8'h20, 16);
        rx_valid = 1; rx_data = 8'h5A; out_ready = 1;
        cyc();
        out_ready = 0;
        check("t3_noovf", 32'(overflow), 0);
        check("t3_level16", 32'(level), 16);
        check("t3_head", 32'(out_data), 32'h21);
        out_ready = 1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("t3_last", 32'(out_data), 32'h5A);
            cyc();
        end
        out_ready = 0;

        // 4) level threshold
        thresh = 5'd4;
        fill(8'h30, 3);
        check("t4_irq3", 32'(irq_thresh), 0);
        wr(8'h33);
        check("t4_irq4", 32'(irq_thresh), 1);
        drain(1);
        check("t4_irq_rd", 32'(irq_thresh), 0);
        drain(3);
        thresh = 5'd0;
        fill(8'h40, 16);
        check("t4_irq_t0", 32'(irq_thresh), 0);
        drain(16);

        // 5) idle timeout
        wr(8'h77);
        for (int k = 1; k <= TT; k++) begin
            sample_tick = 1; cyc();
            if (k == TT - 1) check("t5_tmo639", 32'(rx_timeout), 0);
            if (k == TT)     check("t5_tmo640", 32'(rx_timeout), 1);
        end
        ticks(3);
        check("t5_tmo_hold", 32'(rx_timeout), 1);
        drain(1);
        check("t5_tmo_rd", 32'(rx_timeout), 0);
        wr(8'hA1);
        ticks(600);
        check("t5_tmo600", 32'(rx_timeout), 0);
        wr(8'hA2);
        for (int k = 1; k <= TT; k++) begin
            sample_tick = 1; cyc();
            if (k == TT - 1) check("t5b_tmo639", 32'(rx_timeout), 0);
            if (k == TT)     check("t5b_tmo640", 32'(rx_timeout), 1);
        end
        drain(2);
        check("t5_empty", 32'(out_valid), 0);

        // 6) reset mid-operation, with a write in the reset cycle
        fill(8'h50, 17);
        drain(11);
        check("t6_level5", 32'(level), 5);
        check("t6_ovf", 32'(overflow), 1);
        rstn = 0; rx_valid = 1; rx_data = 8'h99;
        cyc();
        rstn = 1;
        check("t6_level0", 32'(level), 0);
        check("t6_valid0", 32'(out_valid), 0);
        check("t6_ovf0", 32'(overflow), 0);
        check("t6_tmo0", 32'(rx_timeout), 0);
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
